// File: rtl/best_arr_sender.sv
// best_arr_sender: streams the best-index array from its 1-cycle SRAM into the out FIFO in host order.
// Optional feature macro BEST_ARR_CHECKSUM_EN appends a mod-2^DATA_WIDTH sum word after the last index.
module best_arr_sender #(
  parameter int DATA_WIDTH = 11,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int BLOCKING   = 4,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_best_arr,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  out_wfull_n,
  output logic                  out_wenq,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int HALF = ROW_SIZE / 2;
  localparam int NX   = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int XW   = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW   = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int IW   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

`ifdef BEST_ARR_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic                  px_q, px_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [IW-1:0]         xi_q, xi_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef BEST_ARR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  pop;
  logic [2:0]            pending;
  logic                  issue;
  logic                  xi_wrap, y_wrap, x_wrap, last_issue;
  int                    addr_full;
  logic [1:0]            fill;
  logic [DATA_WIDTH-1:0] t0, t1, t2;

  // The pending read counts as the tail of the skid, so read data can leave the cycle it returns.
  always_comb begin
    out_valid = (occ_q != 2'd0) || inflight_q;
    out_data  = '0;
    if (occ_q != 2'd0) out_data = skid0_q;
    else if (inflight_q) out_data = mem_rdata;
    pop       = out_valid && out_wfull_n;
    pending   = 3'(occ_q) + 3'(inflight_q);
    issue     = (state_q == S_RUN) && ((pending - 3'(pop)) < 3'd2);
  end

  // xi wraps early once the column passes HALF, so skipped combos never cost a cycle.
  always_comb begin
    xi_wrap    = (int'(xi_q) == BLOCKING - 1) ||
                 (int'(x_q) * BLOCKING + int'(xi_q) + 1 >= HALF);
    y_wrap     = (int'(y_q) == COL_SIZE - 1);
    x_wrap     = (int'(x_q) == NX - 1);
    last_issue = px_q && x_wrap && y_wrap && xi_wrap;
    addr_full  = int'(px_q) * HALF + int'(y_q) * ROW_SIZE + int'(x_q) * BLOCKING + int'(xi_q);
  end

  always_comb begin
    t0   = skid0_q;
    t1   = skid1_q;
    t2   = mem_rdata;
    fill = occ_q;
    if (inflight_q) begin
      if (occ_q == 2'd0) t0 = mem_rdata;
      else if (occ_q == 2'd1) t1 = mem_rdata;
      fill = occ_q + 2'd1;
    end
    occ_d      = fill - 2'(pop);
    skid0_d    = pop ? t1 : t0;
    skid1_d    = pop ? t2 : t1;
    inflight_d = issue;
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    x_d     = x_q;
    y_d     = y_q;
    xi_d    = xi_q;
`ifdef BEST_ARR_CHECKSUM_EN
    sum_d   = pop ? (sum_q + out_data) : sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (send_best_arr) begin
          state_d = S_RUN;
          px_d    = 1'b0;
          x_d     = '0;
          y_d     = '0;
          xi_d    = '0;
`ifdef BEST_ARR_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_RUN: begin
        if (issue) begin
          if (xi_wrap) begin
            xi_d = '0;
            if (y_wrap) begin
              y_d = '0;
              if (x_wrap) begin
                x_d  = '0;
                px_d = ~px_q;
              end else begin
                x_d = x_q + XW'(1);
              end
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            xi_d = xi_q + IW'(1);
          end
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((occ_d == 2'd0) && !inflight_d) begin
`ifdef BEST_ARR_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef BEST_ARR_CHECKSUM_EN
      S_CSUM: begin
        if (out_wfull_n) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      px_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      xi_q       <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      skid0_q    <= '0;
      skid1_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BEST_ARR_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xi_q       <= xi_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      skid0_q    <= skid0_d;
      skid1_q    <= skid1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BEST_ARR_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign mem_ren   = issue;
  assign mem_raddr = ADDR_WIDTH'(addr_full);
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef BEST_ARR_CHECKSUM_EN
  assign out_wenq  = pop || ((state_q == S_CSUM) && out_wfull_n);
  assign out_wdata = (state_q == S_CSUM) ? sum_q : out_data;
`else
  assign out_wenq  = pop;
  assign out_wdata = out_data;
`endif

endmodule

// File: tb/tb_best_arr_sender.sv
// Scoreboard bench for best_arr_sender: a nested-loop host-order model feeds expected
// read addresses and FIFO words; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_best_arr_sender;
  localparam int DW   = 11;
  localparam int ROW  = 26;
  localparam int COL  = 19;
  localparam int BLK  = 4;
  localparam int HALF = 13;
  localparam int NX   = 4;
  localparam int NQ   = 494;
  localparam int AW   = 9;
`ifdef BEST_ARR_CHECKSUM_EN
  localparam int NWORDS    = NQ + 1;
  localparam int LAST_WORD = 939;
`else
  localparam int NWORDS    = NQ;
  localparam int LAST_WORD = 493;
`endif

  logic          clk = 1'b0;
  logic          rst, send_best_arr, mem_ren, out_wfull_n, out_wenq, busy, done;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata, out_wdata;
  logic [DW-1:0] mem [0:NQ-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_addr_q[$];
  int exp_word_q[$];
  int n_words, n_reads, first_wenq_cyc, last_wenq_cyc, first_ren_cyc, first_addr;
  int done_count, done_cyc, w247, last_word, max_addr, n_edge_reads, start_cyc;

  best_arr_sender dut (
    .clk           (clk),
    .rst           (rst),
    .send_best_arr (send_best_arr),
    .mem_ren       (mem_ren),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata),
    .out_wfull_n   (out_wfull_n),
    .out_wenq      (out_wenq),
    .out_wdata     (out_wdata),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (mem_ren) mem_rdata <= (int'(mem_raddr) < NQ) ? mem[int'(mem_raddr)] : '1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic clear_stats();
    n_words = 0; n_reads = 0; first_wenq_cyc = -1; last_wenq_cyc = -1;
    first_ren_cyc = -1; first_addr = -1; done_count = 0; done_cyc = -1;
    w247 = -1; last_word = -1; max_addr = -1; n_edge_reads = 0;
  endtask

  task automatic push_expected();
    int a;
    int sum;
    sum = 0;
    exp_addr_q.delete();
    exp_word_q.delete();
    for (int px = 0; px < 2; px++)
      for (int x = 0; x < NX; x++)
        for (int y = 0; y < COL; y++)
          for (int xi = 0; xi < BLK; xi++)
            if (x * BLK + xi < HALF) begin
              a = px * HALF + y * ROW + x * BLK + xi;
              exp_addr_q.push_back(a);
              exp_word_q.push_back(int'(mem[a]));
              sum += int'(mem[a]);
            end
`ifdef BEST_ARR_CHECKSUM_EN
    exp_word_q.push_back(sum % 2048);
`endif
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_ren) begin
        if (n_reads == 0) begin
          first_ren_cyc = cyc;
          first_addr    = int'(mem_raddr);
        end
        n_reads++;
        if (int'(mem_raddr) > max_addr) max_addr = int'(mem_raddr);
        if (int'(mem_raddr) % HALF == HALF - 1) n_edge_reads++;
        chk("reads_pending", 32'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) chk("raddr", 32'(mem_raddr), exp_addr_q.pop_front());
      end
      if (out_wenq) begin
        chk("wenq_while_full", 32'(out_wfull_n), 1);
        if (n_words == 0) first_wenq_cyc = cyc;
        last_wenq_cyc = cyc;
        if (n_words == 247) w247 = int'(out_wdata);
        last_word = int'(out_wdata);
        n_words++;
        chk("words_pending", 32'(exp_word_q.size() > 0), 1);
        if (exp_word_q.size() > 0) chk("wdata", 32'(out_wdata), exp_word_q.pop_front());
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic pulse_start();
    send_best_arr = 1'b1;
    start_cyc     = cyc;
    @(posedge clk); #1;
    send_best_arr = 1'b0;
  endtask

  task automatic run_xfer(input bit rand_full, input int restart_at);
    int guard;
    @(posedge clk); #1;
    clear_stats();
    push_expected();
    pulse_start();
    guard = 0;
    while (done_count == 0 && guard < 4000) begin
      out_wfull_n   = rand_full ? ($urandom_range(0, 1) == 1) : 1'b1;
      send_best_arr = (restart_at >= 0) && (n_words == restart_at);
      @(posedge clk); #1;
      guard++;
    end
    send_best_arr = 1'b0;
    out_wfull_n   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("done_pulses", done_count, 1);
    chk("addr_left", exp_addr_q.size(), 0);
    chk("words_left", exp_word_q.size(), 0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < NQ; i++) mem[i] = DW'(i);
    rst = 1'b1;
    send_best_arr = 1'b0;
    out_wfull_n = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_ren", 32'(mem_ren), 0);
    chk("rst_out_wenq", 32'(out_wenq), 0);
    chk("rst_mem_raddr", 32'(mem_raddr), 0);

    // full-speed transfer: order, content and latency
    run_xfer(1'b0, -1);
    chk("t1_words", n_words, NWORDS);
    chk("t1_word247", w247, 13);
    chk("t1_last_word", last_word, LAST_WORD);
    chk("t2_ren_latency", first_ren_cyc - start_cyc, 1);
    chk("t2_wenq_latency", first_wenq_cyc - start_cyc, 2);
    chk("t2_burst_len", last_wenq_cyc - first_wenq_cyc + 1, NWORDS);
    chk("t2_done_latency", done_cyc - last_wenq_cyc, 1);

    // random backpressure
    run_xfer(1'b1, -1);
    chk("t3_words", n_words, NWORDS);
    chk("t3_last_word", last_word, LAST_WORD);

    // boundary columns and a restart attempt mid-run
    run_xfer(1'b0, 200);
    chk("t4_words", n_words, NWORDS);
    chk("t4_edge_reads", n_edge_reads, 2 * COL);
    chk("t4_max_addr", max_addr, NQ - 1);
    chk("t4_reads", n_reads, NQ);

    // reset mid-transfer, then a clean restart
    @(posedge clk); #1;
    clear_stats();
    push_expected();
    pulse_start();
    guard = 0;
    while (n_words < 100 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("t5_reach_100", 32'(n_words >= 100), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_out_wenq", 32'(out_wenq), 0);
    chk("t5_mem_ren", 32'(mem_ren), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_xfer(1'b0, -1);
    chk("t5_restart_addr", first_addr, 0);
    chk("t5_words", n_words, NWORDS);
    chk("t5_last_word", last_word, LAST_WORD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
